// File: rtl/uart_tx_engine.sv
// UART transmitter: one byte per valid/ready handshake, sent as 1 start bit,
// DATA_BITS data bits LSB-first, no parity, STOP_BITS stop bits.
//
// state | meaning
// IDLE  | line high, ready for a byte
// START | start bit (line low) for CLKS_PER_BIT cycles
// DATA  | shift register bit 0 on the line, one bit per CLKS_PER_BIT cycles
// STOP  | line high for STOP_BITS*CLKS_PER_BIT cycles, done in the last one
module uart_tx_engine #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state, state_next;
    logic [CW-1:0]          cyc_cnt, cyc_cnt_next;
    logic [IW-1:0]          bit_idx, bit_idx_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic                   tx_reg, tx_next;
    logic                   unused_data;

    // Bits of tx_data above DATA_BITS-1 are intentionally ignored.
    assign unused_data = ^tx_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cyc_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state     <= state_next;
            cyc_cnt   <= cyc_cnt_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

    // tx_next always holds the line value for the cycle that follows this edge.
    always_comb begin
        state_next   = state;
        cyc_cnt_next = cyc_cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift_reg;
        tx_next      = tx_reg;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (tx_valid) begin
                    state_next   = START;
                    shift_next   = tx_data[DATA_BITS-1:0];
                    cyc_cnt_next = '0;
                    bit_idx_next = '0;
                    tx_next      = 1'b0;
                end
            end
            START: begin
                if (cyc_cnt == BIT_LAST) begin
                    state_next   = DATA;
                    cyc_cnt_next = '0;
                    bit_idx_next = '0;
                    tx_next      = shift_reg[0];
                end else begin
                    cyc_cnt_next = cyc_cnt + 1'b1;
                end
            end
            DATA: begin
                if (cyc_cnt == BIT_LAST) begin
                    cyc_cnt_next = '0;
                    if (bit_idx == IDX_LAST) begin
                        state_next = STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                        shift_next   = shift_reg >> 1;
                        tx_next      = shift_reg[1];
                    end
                end else begin
                    cyc_cnt_next = cyc_cnt + 1'b1;
                end
            end
            STOP: begin
                tx_next = 1'b1;
                if (cyc_cnt == STOP_LAST) begin
                    state_next   = IDLE;
                    cyc_cnt_next = '0;
                end else begin
                    cyc_cnt_next = cyc_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    assign tx       = tx_reg;
    assign tx_ready = (state == IDLE);
    assign tx_busy  = (state != IDLE);
    assign tx_done  = (state == STOP) && (cyc_cnt == STOP_LAST);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: two instances (4 clk/bit 8N1, and 2 clk/bit 5 data
// 2 stop) checked every cycle against a per-cycle waveform model, plus a line decoder.
module tb_uart_tx_engine;
    localparam int CA = 4, DA = 8, SA = 1;
    localparam int CB = 2, DB = 5, SB = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] a_data = '0, b_data = '0;
    logic a_valid = 1'b0, b_valid = 1'b0;
    logic a_ready, a_tx, a_busy, a_done;
    logic b_ready, b_tx, b_busy, b_done;

    int n_cmp = 0;
    int n_mis = 0;
    bit mon_en = 1'b0;
    int cyc = 0;

    logic qa[$];
    logic qb[$];
    int   acc_a[$];
    logic [7:0] rx_q[$];
    int   last_run = 0;

    always #5 clk = ~clk;

    uart_tx_engine #(.CLKS_PER_BIT(CA), .DATA_BITS(DA), .STOP_BITS(SA)) dut_a (
        .clk(clk), .rst_n(rst_n), .tx_data(a_data), .tx_valid(a_valid),
        .tx_ready(a_ready), .tx(a_tx), .tx_busy(a_busy), .tx_done(a_done));

    uart_tx_engine #(.CLKS_PER_BIT(CB), .DATA_BITS(DB), .STOP_BITS(SB)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_data(b_data), .tx_valid(b_valid),
        .tx_ready(b_ready), .tx(b_tx), .tx_busy(b_busy), .tx_done(b_done));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: each accepted byte becomes the list of line values for every cycle of its frame.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) qa.delete();
        else if (qa.size() == 0) begin
            if (a_valid) begin
                acc_a.push_back(cyc);
                for (int r = 0; r < CA; r++) qa.push_back(1'b0);
                for (int k = 0; k < DA; k++)
                    for (int r = 0; r < CA; r++) qa.push_back(a_data[k]);
                for (int r = 0; r < CA * SA; r++) qa.push_back(1'b1);
            end
        end else void'(qa.pop_front());
    end

    always @(posedge clk) begin
        if (!rst_n) qb.delete();
        else if (qb.size() == 0) begin
            if (b_valid) begin
                for (int r = 0; r < CB; r++) qb.push_back(1'b0);
                for (int k = 0; k < DB; k++)
                    for (int r = 0; r < CB; r++) qb.push_back(b_data[k]);
                for (int r = 0; r < CB * SB; r++) qb.push_back(1'b1);
            end
        end else void'(qb.pop_front());
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("a_tx",    a_tx,    qa.size() == 0 ? 1'b1 : qa[0]);
            check("a_ready", a_ready, qa.size() == 0);
            check("a_busy",  a_busy,  qa.size() != 0);
            check("a_done",  a_done,  qa.size() == 1);
            check("b_tx",    b_tx,    qb.size() == 0 ? 1'b1 : qb[0]);
            check("b_ready", b_ready, qb.size() == 0);
            check("b_busy",  b_busy,  qb.size() != 0);
            check("b_done",  b_done,  qb.size() == 1);
        end
    end

    // Line decoder for instance A (mid-bit sampling) and high-run measurement.
    bit rx_act = 1'b0;
    int rx_cnt = 0;
    int run = 0;
    logic prev_a = 1'b1;
    logic [7:0] rx_sh = '0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (a_tx === 1'b1) run++;
            else begin
                if (run > 0) last_run = run;
                run = 0;
            end
            if (!rst_n) rx_act = 1'b0;
            else if (!rx_act) begin
                if (prev_a && !a_tx) begin
                    rx_act = 1'b1;
                    rx_cnt = 0;
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % CA == CA / 2 && rx_cnt < CA * (DA + 1))
                    rx_sh[rx_cnt / CA - 1] = a_tx;
                if (rx_cnt == CA * (DA + 1) + CA / 2) begin
                    check("rx_stop", a_tx, 1'b1);
                    rx_q.push_back(rx_sh);
                    rx_act = 1'b0;
                end
            end
            prev_a = a_tx;
        end
    end

    task automatic send(input bit sel, input logic [7:0] d, input bit hold);
        int n = 0;
        if (sel) begin b_valid = 1'b1; b_data = d; end
        else     begin a_valid = 1'b1; a_data = d; end
        @(negedge clk);
        while (!(sel ? b_ready : a_ready) && n < 200) begin
            n++;
            @(negedge clk);
        end
        check(sel ? "b_accept" : "a_accept", sel ? b_ready : a_ready, 1'b1);
        @(posedge clk);
        #1;
        if (!hold) begin
            if (sel) b_valid = 1'b0; else a_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(input bit sel);
        int n = 0;
        @(negedge clk);
        while (!(sel ? b_ready : a_ready) && n < 200) begin
            n++;
            @(negedge clk);
        end
        check(sel ? "b_idle" : "a_idle", sel ? b_ready : a_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic rx_expect(input string tag, input logic [7:0] b);
        check({tag, "_present"}, rx_q.size() != 0, 1'b1);
        if (rx_q.size() != 0) check(tag, rx_q.pop_front(), b);
    endtask

    initial begin
        logic [9:0] a5_seq;
        logic [7:0] d;
        int n;
        a5_seq = 10'b1101001010;

        // Reset values, then quiet idle
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_tx", a_tx, 1'b1);
        check("rst_ready", a_ready, 1'b1);
        check("rst_busy", a_busy, 1'b0);
        check("rst_done", a_done, 1'b0);
        repeat (20) @(negedge clk);
        check("idle20_tx", a_tx, 1'b1);
        check("idle20_ready", a_ready, 1'b1);
        @(posedge clk);
        #1;

        // Single byte 0xA5
        rx_q.delete();
        send(0, 8'hA5, 0);
        for (int j = 1; j <= 41; j++) begin
            @(negedge clk);
            if (j <= 40 && (j - 1) % 4 == 0) check("a5_bit", a_tx, a5_seq[(j - 1) / 4]);
            if (j == 39) check("a5_done_early", a_done, 1'b0);
            if (j == 40) check("a5_done", a_done, 1'b1);
            if (j == 41) check("a5_ready", a_ready, 1'b1);
        end
        rx_expect("rx_a5", 8'hA5);
        @(posedge clk);
        #1;

        // Back-to-back 0x00 then 0xFF with tx_valid held
        rx_q.delete();
        send(0, 8'h00, 1);
        send(0, 8'hFF, 0);
        check("b2b_spacing", acc_a[acc_a.size() - 1] - acc_a[acc_a.size() - 2], 41);
        repeat (2) @(posedge clk);
        #1;
        check("b2b_gap_high", last_run, 5);
        wait_idle(0);
        rx_expect("rx_b2b_0", 8'h00);
        rx_expect("rx_b2b_1", 8'hFF);

        // tx_data changed mid-frame while tx_valid is held
        rx_q.delete();
        send(0, 8'h3C, 1);
        repeat (10) begin @(posedge clk); #1; end
        a_data = 8'hC3;
        send(0, 8'hC3, 0);
        wait_idle(0);
        rx_expect("rx_held_0", 8'h3C);
        rx_expect("rx_held_1", 8'hC3);

        // Reset during data bit 3 of 0x55
        rx_q.delete();
        send(0, 8'h55, 0);
        repeat (17) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midrst_tx", a_tx, 1'b1);
        check("midrst_ready", a_ready, 1'b1);
        check("midrst_rx_empty", rx_q.size(), 0);
        @(posedge clk);
        #1;
        send(0, 8'h81, 0);
        wait_idle(0);
        rx_expect("rx_after_rst", 8'h81);

        // Reset and handshake at the same edge: reset wins
        a_valid = 1'b1;
        a_data = 8'hAA;
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        a_valid = 1'b0;
        @(negedge clk);
        check("rstwin_ready", a_ready, 1'b1);
        check("rstwin_tx", a_tx, 1'b1);
        @(posedge clk);
        #1;

        // Parameter corner: 5 data, 2 stop, 2 clk/bit
        send(1, 8'h1F, 0);
        for (int j = 1; j <= 17; j++) begin
            @(negedge clk);
            if (j <= 16) check("corner_line", b_tx, (j <= 2) ? 1'b0 : 1'b1);
            if (j <= 16) check("corner_done", b_done, j == 16);
            if (j == 17) check("corner_ready", b_ready, 1'b1);
        end
        @(posedge clk);
        #1;

        // Randomized traffic on both instances
        rx_q.delete();
        for (int i = 0; i < 30; i++) begin
            d = 8'($urandom);
            send(0, d, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) a_data = 8'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                n = $urandom_range(1, 30);
                repeat (n) @(posedge clk);
                #1 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
            n = $urandom_range(0, 3);
            repeat (n) begin @(posedge clk); #1; end
        end
        a_valid = 1'b0;
        wait_idle(0);
        for (int i = 0; i < 30; i++) begin
            d = 8'($urandom);
            send(1, d, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) b_data = 8'($urandom);
            n = $urandom_range(0, 3);
            repeat (n) begin @(posedge clk); #1; end
        end
        b_valid = 1'b0;
        wait_idle(1);
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
